instr_cache_refill: RTL and testbench
=====================================

# instr_cache_refill

Instruction-cache line refill engine that sits directly downstream of the instruction cache controller. When the fetch stage misses and replacement is permitted, it latches the missing line address, issues one burst read to the next memory level, and streams the returned words into the cache data array with per-word write strobes. It then pulses a completion flag so the cache can mark the line valid and the hazard unit can release the fetch stall.

## Interface

- ADDR_WIDTH, 32, fetch/memory address width
- WORD_WIDTH, 32, instruction word width
- BLOCK_WORDS, 4, words per cache line; power of two, ≥2
- Clock and reset (already decided): one clock, `clk_i`; `reset_i` is asynchronous and active-high.
- clk_i  in  1  clock
- reset_i  in  1  asynchronous, active-high reset
- instr_hit_f_i  in  1  fetch-stage hit from cache controller
- ic_repl_permit_i  in  1  replacement permitted (controller gate)
- pc_f_i  in  ADDR_WIDTH  fetch PC
- mem_req_o  out  1  burst read request, held until accepted
- mem_addr_o  out  ADDR_WIDTH  line-aligned burst base address
- mem_ack_i  in  1  request accepted
- mem_rvalid_i  in  1  read beat valid
- mem_rdata_i  in  WORD_WIDTH  read beat data
- fill_we_o  out  1  cache data-array write strobe
- fill_addr_o  out  ADDR_WIDTH  line base address being filled
- fill_word_idx_o  out  $clog2(BLOCK_WORDS)  word offset within line
- fill_data_o  out  WORD_WIDTH  word to write
- fill_done_o  out  1  one-cycle pulse: line complete
- refill_busy_o  out  1  engine not idle; fetch stall source

## Operation

- OFFS = $clog2(BLOCK_WORDS)+2. Line base = {pc_f_i[ADDR_WIDTH-1:OFFS], OFFS'b0}.
- States: IDLE(0), REQ(1), FILL(2), DONE(3).
- IDLE:
  - On clock edge with instr_hit_f_i=0 and ic_repl_permit_i=1: latch line base into line_addr, then → REQ.
  - Miss with permit=0: remain IDLE; no request.
- REQ:
  - mem_req_o=1; mem_addr_o=line_addr.
  - On edge with mem_ack_i=1: beat counter ← 0, → FILL.
  - mem_rvalid_i in REQ is ignored.
- FILL:
  - fill_we_o = mem_rvalid_i (combinational).
  - fill_word_idx_o = counter; fill_data_o = mem_rdata_i.
  - Each valid beat increments the counter.
  - Beats may have gaps; the counter holds across gaps.
  - Valid beat with counter = BLOCK_WORDS-1: counter wraps to 0, → DONE.
- DONE: fill_done_o=1 for exactly one cycle, then → IDLE unconditionally. No new miss is accepted in DONE.
- fill_addr_o = line_addr in all states.
- refill_busy_o = (state != IDLE).
- mem_req_o = (state == REQ). mem_addr_o = line_addr when requesting, 0 otherwise.
- Inputs are sampled only in their owning state: permit and hit in IDLE, ack in REQ, rvalid in FILL. Changes in ic_repl_permit_i or pc_f_i after the start are ignored; an in-flight refill always completes.
- Beats arriving in IDLE or DONE are dropped; fill_we_o stays 0.

## Timing

- Reset values: state=IDLE, counter=0, line_addr=0. All outputs are 0: mem_req_o, mem_addr_o, fill_we_o, fill_addr_o, fill_word_idx_o, fill_done_o, refill_busy_o.
- Reset asserted mid-operation: state returns to IDLE immediately (asynchronous). mem_req_o and fill_we_o drop in the same cycle without waiting for a clock. Outstanding memory beats after reset are ignored.
- Latency with ack in the first REQ cycle and back-to-back beats starting the cycle after ack:
  - miss edge → mem_req_o high: 1 cycle
  - first fill_we_o: 2 cycles after the miss edge
  - fill_done_o: BLOCK_WORDS+2 cycles after the miss edge
  - busy low: BLOCK_WORDS+3 cycles after the miss edge
- Earliest restart: the first IDLE cycle after DONE.

## Test plan

- Reset → all outputs 0, state IDLE; then hold instr_hit_f_i=1, ic_repl_permit_i=1 for 5 cycles → mem_req_o stays 0, refill_busy_o stays 0.
- Miss with permit=0, pc_f_i=0x0000_1234, for 3 cycles → no request; state stays IDLE.
- Miss with permit=1, pc_f_i=0x0000_1234, BLOCK_WORDS=4; ack after 2 REQ cycles; beats 0xA0..0xA3 back-to-back →
  - mem_addr_o=0x0000_1230
  - fill_we_o high 4 cycles with idx 0,1,2,3 and matching data
  - fill_done_o pulses one cycle after the last beat
  - busy low on the following cycle
- Same miss with gapped beats (rvalid pattern 1,0,0,1,1,0,1) → exactly 4 writes, idx 0..3 in order; idx holds across gaps.
- Permit drops and pc_f_i changes to 0x0000_2000 during FILL → fill_addr_o stays 0x0000_1230; fill completes normally.
- Reset asserted after beat 1 of 4 → state IDLE and outputs 0 before the next edge. Beats 2–3 arriving after reset release produce no fill_we_o. A new miss then restarts at idx 0.

Source files
------------

// File: rtl/instr_cache_refill.sv
// Instruction-cache line refill engine: on a permitted miss it latches the line base,
// issues one burst read and streams the returned beats into the cache data array.
module instr_cache_refill #(
  parameter int ADDR_WIDTH  = 32,
  parameter int WORD_WIDTH  = 32,
  parameter int BLOCK_WORDS = 4
) (
  input  logic                           clk_i,
  input  logic                           reset_i,
  input  logic                           instr_hit_f_i,
  input  logic                           ic_repl_permit_i,
  input  logic [ADDR_WIDTH-1:0]          pc_f_i,
  output logic                           mem_req_o,
  output logic [ADDR_WIDTH-1:0]          mem_addr_o,
  input  logic                           mem_ack_i,
  input  logic                           mem_rvalid_i,
  input  logic [WORD_WIDTH-1:0]          mem_rdata_i,
  output logic                           fill_we_o,
  output logic [ADDR_WIDTH-1:0]          fill_addr_o,
  output logic [$clog2(BLOCK_WORDS)-1:0] fill_word_idx_o,
  output logic [WORD_WIDTH-1:0]          fill_data_o,
  output logic                           fill_done_o,
  output logic                           refill_busy_o
);

  localparam int IDX_W = $clog2(BLOCK_WORDS);
  localparam int OFFS  = IDX_W + 2;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BLOCK_WORDS - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    FILL = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t state;
  state_t next_state;

  logic [IDX_W-1:0]      beat_cnt;
  logic [ADDR_WIDTH-1:0] line_addr;
  logic [ADDR_WIDTH-1:0] line_base;
  logic                  start;
  logic                  beat;
  logic                  last_beat;
  logic [OFFS-1:0]       pc_low_unused;

  // Byte and word offset bits of the PC never reach the line base.
  assign pc_low_unused = pc_f_i[OFFS-1:0];
  assign line_base     = {pc_f_i[ADDR_WIDTH-1:OFFS], {OFFS{1'b0}}};

  assign start     = (state == IDLE) && !instr_hit_f_i && ic_repl_permit_i;
  assign beat      = (state == FILL) && mem_rvalid_i;
  assign last_beat = beat && (beat_cnt == LAST_IDX);

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      line_addr <= '0;
      beat_cnt  <= '0;
    end else begin
      if (start) begin
        line_addr <= line_base;
      end
      if ((state == REQ) && mem_ack_i) begin
        beat_cnt <= '0;
      end else if (beat) begin
        beat_cnt <= beat_cnt + IDX_W'(1);
      end
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (start)     next_state = REQ;
      REQ:     if (mem_ack_i) next_state = FILL;
      FILL:    if (last_beat) next_state = DONE;
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  assign mem_req_o       = (state == REQ);
  assign mem_addr_o      = (state == REQ) ? line_addr : '0;
  assign fill_we_o       = beat;
  assign fill_addr_o     = line_addr;
  assign fill_word_idx_o = beat_cnt;
  assign fill_data_o     = mem_rdata_i;
  assign fill_done_o     = (state == DONE);
  assign refill_busy_o   = (state != IDLE);

endmodule

// File: tb/tb_instr_cache_refill.sv
// Self-checking bench for instr_cache_refill: expected fill writes are queued as beats
// are driven and popped by a monitor whenever the engine strobes fill_we_o.
module tb_instr_cache_refill;

  localparam int AW = 32;
  localparam int WW = 32;
  localparam int BW = 4;
  localparam int IW = $clog2(BW);

  logic          clk = 1'b0;
  logic          reset_i = 1'b1;
  logic          instr_hit_f_i = 1'b1;
  logic          ic_repl_permit_i = 1'b0;
  logic [AW-1:0] pc_f_i = '0;
  logic          mem_req_o;
  logic [AW-1:0] mem_addr_o;
  logic          mem_ack_i = 1'b0;
  logic          mem_rvalid_i = 1'b0;
  logic [WW-1:0] mem_rdata_i = '0;
  logic          fill_we_o;
  logic [AW-1:0] fill_addr_o;
  logic [IW-1:0] fill_word_idx_o;
  logic [WW-1:0] fill_data_o;
  logic          fill_done_o;
  logic          refill_busy_o;

  int errors = 0;
  int checks = 0;
  int done_count = 0;
  logic [IW+WW-1:0] sb[$];
  logic [IW+WW-1:0] exp_word;

  instr_cache_refill #(.ADDR_WIDTH(AW), .WORD_WIDTH(WW), .BLOCK_WORDS(BW)) dut (
    .clk_i(clk), .reset_i(reset_i),
    .instr_hit_f_i(instr_hit_f_i), .ic_repl_permit_i(ic_repl_permit_i), .pc_f_i(pc_f_i),
    .mem_req_o(mem_req_o), .mem_addr_o(mem_addr_o), .mem_ack_i(mem_ack_i),
    .mem_rvalid_i(mem_rvalid_i), .mem_rdata_i(mem_rdata_i),
    .fill_we_o(fill_we_o), .fill_addr_o(fill_addr_o), .fill_word_idx_o(fill_word_idx_o),
    .fill_data_o(fill_data_o), .fill_done_o(fill_done_o), .refill_busy_o(refill_busy_o)
  );

  always #5 clk = ~clk;

  // Every write strobe must match the oldest beat the bench expects to land.
  always @(negedge clk) begin
    if (fill_we_o) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("[TB] FAIL unexpected_write got idx=%0d data=%h, want no write", fill_word_idx_o, fill_data_o);
      end else begin
        exp_word = sb.pop_front();
        if ({fill_word_idx_o, fill_data_o} !== exp_word) begin
          errors++;
          $display("[TB] FAIL fill_write got idx=%0d data=%h, want idx=%0d data=%h",
                   fill_word_idx_o, fill_data_o, exp_word[IW+WW-1:WW], exp_word[WW-1:0]);
        end
      end
    end
    if (fill_done_o) done_count++;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic start_miss(input logic [AW-1:0] pc);
    instr_hit_f_i = 1'b0;
    ic_repl_permit_i = 1'b1;
    pc_f_i = pc;
    step();
    instr_hit_f_i = 1'b1;
    ic_repl_permit_i = 1'b0;
  endtask

  task automatic push_beat(input int idx, input logic [WW-1:0] d);
    mem_rvalid_i = 1'b1;
    mem_rdata_i = d;
    sb.push_back({IW'(idx), d});
  endtask

  task automatic test_reset();
    @(negedge clk);
    checks++;
    if ({mem_req_o, mem_addr_o, fill_we_o, fill_addr_o, fill_word_idx_o, fill_done_o, refill_busy_o} !== '0) begin
      errors++;
      $display("[TB] FAIL reset_outputs got req=%b addr=%h we=%b faddr=%h idx=%0d done=%b busy=%b, want all 0",
               mem_req_o, mem_addr_o, fill_we_o, fill_addr_o, fill_word_idx_o, fill_done_o, refill_busy_o);
    end
    reset_i = 1'b0;
    instr_hit_f_i = 1'b1;
    ic_repl_permit_i = 1'b1;
    repeat (5) begin
      step();
      @(negedge clk);
      checks++;
      if ({mem_req_o, refill_busy_o} !== 2'b00) begin
        errors++;
        $display("[TB] FAIL hit_idle got req=%b busy=%b, want 0 0", mem_req_o, refill_busy_o);
      end
    end
  endtask

  task automatic test_no_permit();
    instr_hit_f_i = 1'b0;
    ic_repl_permit_i = 1'b0;
    pc_f_i = 32'h0000_1234;
    repeat (3) begin
      step();
      @(negedge clk);
      checks++;
      if ({mem_req_o, refill_busy_o} !== 2'b00) begin
        errors++;
        $display("[TB] FAIL no_permit got req=%b busy=%b, want 0 0", mem_req_o, refill_busy_o);
      end
    end
    instr_hit_f_i = 1'b1;
  endtask

  task automatic test_back_to_back();
    int d0;
    d0 = done_count;
    start_miss(32'h0000_1234);
    @(negedge clk);
    checks++;
    if ({mem_req_o, mem_addr_o, refill_busy_o} !== {1'b1, 32'h0000_1230, 1'b1}) begin
      errors++;
      $display("[TB] FAIL req_issue got req=%b addr=%h busy=%b, want 1 00001230 1", mem_req_o, mem_addr_o, refill_busy_o);
    end
    step();
    mem_ack_i = 1'b1;
    mem_rvalid_i = 1'b1;
    mem_rdata_i = 32'hDEAD_BEEF;
    @(negedge clk);
    checks++;
    if ({mem_req_o, fill_we_o} !== 2'b10) begin
      errors++;
      $display("[TB] FAIL req_held got req=%b we=%b, want 1 0", mem_req_o, fill_we_o);
    end
    step();
    mem_ack_i = 1'b0;
    for (int i = 0; i < BW; i++) begin
      push_beat(i, 32'hA0 + i);
      @(negedge clk);
      checks++;
      if (fill_we_o !== 1'b1) begin
        errors++;
        $display("[TB] FAIL b2b_we beat %0d got %b, want 1", i, fill_we_o);
      end
      step();
    end
    mem_rvalid_i = 1'b0;
    @(negedge clk);
    checks++;
    if ({fill_done_o, refill_busy_o} !== 2'b11) begin
      errors++;
      $display("[TB] FAIL done_pulse got done=%b busy=%b, want 1 1", fill_done_o, refill_busy_o);
    end
    step();
    @(negedge clk);
    checks++;
    if ({fill_done_o, refill_busy_o} !== 2'b00 || sb.size() != 0 || done_count - d0 != 1) begin
      errors++;
      $display("[TB] FAIL b2b_end got done=%b busy=%b pending=%0d pulses=%0d, want 0 0 0 1",
               fill_done_o, refill_busy_o, sb.size(), done_count - d0);
    end
  endtask

  task automatic test_gapped();
    logic [6:0] pat;
    int n;
    pat = 7'b1011001;
    n = 0;
    start_miss(32'h0000_1234);
    mem_ack_i = 1'b1;
    step();
    mem_ack_i = 1'b0;
    for (int i = 0; i < 7; i++) begin
      if (pat[i]) begin
        push_beat(n, 32'hB0 + n);
      end else begin
        mem_rvalid_i = 1'b0;
        mem_rdata_i = 32'h5555_5555;
      end
      @(negedge clk);
      checks++;
      if ({fill_we_o, fill_word_idx_o} !== {pat[i], IW'(n)}) begin
        errors++;
        $display("[TB] FAIL gap_idx cycle %0d got we=%b idx=%0d, want we=%b idx=%0d", i, fill_we_o, fill_word_idx_o, pat[i], n);
      end
      if (pat[i]) n++;
      step();
    end
    mem_rvalid_i = 1'b0;
    @(negedge clk);
    checks++;
    if (fill_done_o !== 1'b1 || sb.size() != 0) begin
      errors++;
      $display("[TB] FAIL gap_done got done=%b pending=%0d, want 1 0", fill_done_o, sb.size());
    end
    step();
  endtask

  task automatic test_permit_drop();
    start_miss(32'h0000_1234);
    mem_ack_i = 1'b1;
    step();
    mem_ack_i = 1'b0;
    for (int i = 0; i < BW; i++) begin
      push_beat(i, 32'hC0 + i);
      pc_f_i = 32'h0000_2000;
      instr_hit_f_i = 1'b0;
      ic_repl_permit_i = (i % 2 == 1);
      @(negedge clk);
      checks++;
      if (fill_addr_o !== 32'h0000_1230) begin
        errors++;
        $display("[TB] FAIL fill_addr_hold beat %0d got %h, want 00001230", i, fill_addr_o);
      end
      step();
    end
    mem_rvalid_i = 1'b0;
    instr_hit_f_i = 1'b0;
    ic_repl_permit_i = 1'b1;
    @(negedge clk);
    checks++;
    if (fill_done_o !== 1'b1) begin
      errors++;
      $display("[TB] FAIL drop_done got %b, want 1", fill_done_o);
    end
    step();
    @(negedge clk);
    checks++;
    if ({mem_req_o, refill_busy_o, fill_addr_o} !== {2'b00, 32'h0000_1230}) begin
      errors++;
      $display("[TB] FAIL done_ignores_miss got req=%b busy=%b faddr=%h, want 0 0 00001230",
               mem_req_o, refill_busy_o, fill_addr_o);
    end
    step();
    instr_hit_f_i = 1'b1;
    ic_repl_permit_i = 1'b0;
    @(negedge clk);
    checks++;
    if ({mem_req_o, mem_addr_o} !== {1'b1, 32'h0000_2000}) begin
      errors++;
      $display("[TB] FAIL earliest_restart got req=%b addr=%h, want 1 00002000", mem_req_o, mem_addr_o);
    end
    mem_ack_i = 1'b1;
    step();
    mem_ack_i = 1'b0;
    for (int i = 0; i < BW; i++) begin
      push_beat(i, 32'hD0 + i);
      step();
    end
    mem_rvalid_i = 1'b0;
    step();
    @(negedge clk);
    checks++;
    if (refill_busy_o !== 1'b0 || sb.size() != 0) begin
      errors++;
      $display("[TB] FAIL restart_complete got busy=%b pending=%0d, want 0 0", refill_busy_o, sb.size());
    end
  endtask

  task automatic test_reset_mid();
    start_miss(32'h0000_1234);
    mem_ack_i = 1'b1;
    step();
    mem_ack_i = 1'b0;
    push_beat(0, 32'hE0);
    step();
    push_beat(1, 32'hE1);
    step();
    mem_rvalid_i = 1'b1;
    mem_rdata_i = 32'hE2;
    reset_i = 1'b1;
    #1;
    checks++;
    if ({mem_req_o, mem_addr_o, fill_we_o, fill_addr_o, fill_word_idx_o, fill_done_o, refill_busy_o} !== '0) begin
      errors++;
      $display("[TB] FAIL async_reset got req=%b we=%b faddr=%h idx=%0d done=%b busy=%b, want all 0",
               mem_req_o, fill_we_o, fill_addr_o, fill_word_idx_o, fill_done_o, refill_busy_o);
    end
    @(negedge clk);
    reset_i = 1'b0;
    step();
    mem_rdata_i = 32'hE3;
    @(negedge clk);
    checks++;
    if ({fill_we_o, refill_busy_o} !== 2'b00) begin
      errors++;
      $display("[TB] FAIL stale_beats got we=%b busy=%b, want 0 0", fill_we_o, refill_busy_o);
    end
    step();
    mem_rvalid_i = 1'b0;
    start_miss(32'h0000_1234);
    mem_ack_i = 1'b1;
    step();
    mem_ack_i = 1'b0;
    push_beat(0, 32'hF0);
    @(negedge clk);
    checks++;
    if ({fill_we_o, fill_word_idx_o} !== {1'b1, IW'(0)}) begin
      errors++;
      $display("[TB] FAIL restart_idx got we=%b idx=%0d, want 1 0", fill_we_o, fill_word_idx_o);
    end
    step();
    for (int i = 1; i < BW; i++) begin
      push_beat(i, 32'hF0 + i);
      step();
    end
    mem_rvalid_i = 1'b0;
    @(negedge clk);
    checks++;
    if (fill_done_o !== 1'b1 || sb.size() != 0) begin
      errors++;
      $display("[TB] FAIL reset_restart_done got done=%b pending=%0d, want 1 0", fill_done_o, sb.size());
    end
    step();
  endtask

  initial begin
    test_reset();
    test_no_permit();
    test_back_to_back();
    test_gapped();
    test_permit_drop();
    test_reset_mid();
    @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
